// File: rtl/w4a8_dot_accumulator.sv
// K-dimension accumulator behind the W4A8 adder tree: tracks valid/last through the
// tree latency, saturating-accumulates tree sums, and buffers results with credit flow.
module w4a8_dot_accumulator_chk #(
    parameter int OUT_DEPTH = 2
) (
    input logic clk,
    input logic rst,
    input logic push_i,
    input logic pop_i,
    input logic full_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i && !pop_i))
        else $error("output FIFO push while full without pop");
endmodule

module w4a8_dot_accumulator #(
    parameter int N         = 64,
    parameter int PROD_W    = 12,
    parameter int SUM_W     = PROD_W + $clog2(N),
    parameter int TREE_LAT  = $clog2(N) + 1,
    parameter int ACC_W     = 32,
    parameter int OUT_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic signed [SUM_W-1:0] sum_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sat
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int CRD_W = $clog2(OUT_DEPTH + TREE_LAT + 1) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [TREE_LAT-1:0] v_q, l_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                sat_q, sat_d;
    logic [ACC_W-1:0]    mem_data_q [OUT_DEPTH];
    logic                mem_sat_q  [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                accept_s, tail_v_s, tail_l_s, push_s, pop_s, full_s, clamp_now_s;
    logic [ACC_W:0]      sum_ext_s, nxt_s;
    logic [ACC_W-1:0]    clamped_s;

    function automatic logic [CRD_W-1:0] popcount(input logic [TREE_LAT-1:0] bits);
        logic [CRD_W-1:0] n;
        n = '0;
        for (int i = 0; i < TREE_LAT; i++) begin
            n = n + CRD_W'(bits[i]);
        end
        return n;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUT_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Each in-flight last reserves a FIFO slot so the free-running tree never overruns it.
    assign in_ready  = (CRD_W'(count_q) + popcount(l_q)) < CRD_W'(OUT_DEPTH);
    assign accept_s  = in_valid && in_ready;
    assign tail_v_s  = v_q[TREE_LAT-1];
    assign tail_l_s  = l_q[TREE_LAT-1];
    assign push_s    = tail_v_s && tail_l_s;
    assign out_valid = (count_q != '0);
    assign pop_s     = out_valid && out_ready;
    assign full_s    = (count_q == CNT_W'(OUT_DEPTH));
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_sat   = mem_sat_q[rd_ptr_q];

    // Saturating accumulate of the aligned tree sum and next accumulator state.
    always_comb begin
        sum_ext_s   = {{(ACC_W+1-SUM_W){sum_in[SUM_W-1]}}, sum_in};
        nxt_s       = {acc_q[ACC_W-1], acc_q} + sum_ext_s;
        clamp_now_s = nxt_s[ACC_W] ^ nxt_s[ACC_W-1];
        if (!clamp_now_s) begin
            clamped_s = nxt_s[ACC_W-1:0];
        end else if (nxt_s[ACC_W]) begin
            clamped_s = ACC_MIN;
        end else begin
            clamped_s = ACC_MAX;
        end
        acc_d = acc_q;
        sat_d = sat_q;
        if (tail_v_s) begin
            if (tail_l_s) begin
                acc_d = '0;
                sat_d = 1'b0;
            end else begin
                acc_d = clamped_s;
                sat_d = sat_q | clamp_now_s;
            end
        end else begin
            acc_d = acc_q;
            sat_d = sat_q;
        end
    end

    // Tracking pipeline, accumulator and output FIFO state.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            l_q      <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_sat_q[i]  <= 1'b0;
            end
        end else begin
            v_q   <= (v_q << 1) | TREE_LAT'(accept_s);
            l_q   <= (l_q << 1) | TREE_LAT'(accept_s && in_last);
            acc_q <= acc_d;
            sat_q <= sat_d;
            if (push_s) begin
                mem_data_q[wr_ptr_q] <= clamped_s;
                mem_sat_q[wr_ptr_q]  <= sat_q | clamp_now_s;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    w4a8_dot_accumulator_chk #(.OUT_DEPTH(OUT_DEPTH)) u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_s),
        .pop_i  (pop_s),
        .full_i (full_s)
    );
endmodule

// File: tb/tb_w4a8_dot_accumulator.sv
// Scoreboard bench: a tree model replays accepted sums after the tree latency and a
// saturating reference model queues expected results for an independent monitor.
module tb_w4a8_dot_accumulator;
    localparam int TREE_LAT = 3;
    localparam int ACC_MAXV = 32767;
    localparam int ACC_MINV = -32768;

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic signed [15:0] sum_in = 16'sh07FF;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic               out_sat;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   sum_at [int];
    exp_t sb [$];
    int   m_acc = 0;
    bit   m_sat = 1'b0;
    int   last_acc = 0;
    bit   rand_done = 1'b0;

    w4a8_dot_accumulator #(.N(4), .PROD_W(14), .ACC_W(16), .OUT_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer accumulation with clamping to the 16-bit signed range.
    task automatic model_accept(input int s, input bit last);
        int  nxt;
        bit  clamp;
        nxt   = m_acc + s;
        clamp = 1'b0;
        if (nxt > ACC_MAXV) begin nxt = ACC_MAXV; clamp = 1'b1; end
        else if (nxt < ACC_MINV) begin nxt = ACC_MINV; clamp = 1'b1; end
        if (last) begin
            sb.push_back('{nxt, m_sat | clamp});
            m_acc = 0;
            m_sat = 1'b0;
        end else begin
            m_acc = nxt;
            m_sat = m_sat | clamp;
        end
    endtask

    task automatic beat(input int s, input bit last);
        int waited = 0;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        sum_at[cyc + TREE_LAT] = s;
        model_accept(s, last);
        last_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        m_acc = 0;
        m_sat = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Tree model: the sum of a beat accepted in cycle c appears in cycle c+TREE_LAT.
    initial begin
        forever begin
            @(negedge clk);
            sum_in = sum_at.exists(cyc) ? 16'(sum_at[cyc]) : 16'sh07FF;
        end
    end

    // Monitor: compare every popped FIFO head against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", out_data, 0);
                    check("unexpected_result_valid", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", int'(out_data), e.data);
                    check("out_sat", out_sat, e.sat);
                end
            end
        end
    end

    initial begin
        int s;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic group 10, -3, 7 and latency of the result
        beat(10, 1'b0); beat(-3, 1'b0); beat(7, 1'b1);
        while (cyc < last_acc + TREE_LAT) @(negedge clk);
        check("latency_before", out_valid, 0);
        @(negedge clk);
        check("latency_at", out_valid, 1);
        idle(8);

        // Back-to-back single-beat groups
        beat(5, 1'b1); beat(-5, 1'b1);
        check("ready_drop", in_ready, 0);
        beat(100, 1'b1);
        idle(8);

        // Backpressure
        out_ready = 1'b0;
        beat(11, 1'b1); beat(-22, 1'b1);
        check("bp_ready_drop", in_ready, 0);
        idle(6);
        check("bp_fifo_valid", out_valid, 1);
        check("bp_fifo_full_ready", in_ready, 0);
        out_ready = 1'b1;
        beat(33, 1'b1);
        idle(8);

        // Saturation then a clean group
        beat(30000, 1'b0); beat(30000, 1'b0); beat(-100, 1'b1);
        beat(1, 1'b1);
        idle(8);

        // Gaps inside a group
        beat(4, 1'b0); idle(2); beat(6, 1'b1);
        idle(8);

        // Reset one cycle before the sum arrives
        beat(50, 1'b0);
        do_reset();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        beat(2, 1'b1);
        idle(8);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    if ($urandom_range(0, 3) == 0) s = int'($signed(16'($urandom_range(0, 65535))));
                    else s = int'($urandom_range(0, 2000)) - 1000;
                    beat(s, $urandom_range(0, 3) == 0);
                end
                beat(1, 1'b1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        idle(2);
        check("sb_drain", sb.size(), 0);
        check("final_out_valid", out_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
